// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: default widths,
// controller state encoding and the request word layout.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_VERIFY = 2'd3
  } state_t;

  // Request word as stored in the FIFO, MSB first: {write, adr, data}.
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] adr;
    logic [DATA_W_DEF-1:0] data;
  } req_t;

  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO. DEPTH must be a power of two so the
// pointers wrap naturally; a push while full is dropped even if a pop
// happens in the same cycle.
module mem_req_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = storage[rd_ptr];

  // Entry storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Requester-side controller for the 32x8 single-port memory.
// Optional build macro: MEM_WR_VERIFY_EN adds a read-back check after
// every write and reports a mismatch on rsp_err.
//
//  state  | meaning
//  IDLE   | waiting for a queued request; pops and drives the bus when one exists
//  ACCESS | one-cycle bus access (write commits / read data sampled at closing edge)
//  VERIFY | write read-back cycle, only with MEM_WR_VERIFY_EN
//  RESP   | response held on rsp_* until the consumer takes it
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wen,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int REQ_W = req_width(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t            state, state_nxt;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0]  fifo_din, fifo_dout;
  // Occupancy is not needed by the FSM; kept wired for debug visibility.
  logic [CNT_W-1:0]  unused_fifo_count;

  logic              head_write;
  logic [ADDR_W-1:0] head_adr;
  logic [DATA_W-1:0] head_data;

  logic [ADDR_W-1:0] mem_adr_nxt;
  logic [DATA_W-1:0] mem_data_nxt;
  logic              mem_wen_nxt, mem_read_nxt;
  logic              rsp_valid_nxt, rsp_write_nxt;
  logic [DATA_W-1:0] rsp_data_nxt;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign fifo_din  = {req_write, req_adr, req_data};
  assign {head_write, head_adr, head_data} = fifo_dout;

  mem_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

`ifdef MEM_WR_VERIFY_EN
  logic rsp_err_q, rsp_err_nxt;
  assign rsp_err = rsp_err_q;

  // Error flag register; only meaningful on write acks after read-back.
  always_ff @(posedge clk) begin
    if (rst) rsp_err_q <= 1'b0;
    else     rsp_err_q <= rsp_err_nxt;
  end
`else
  assign rsp_err = 1'b0;
`endif

  // Next-state and next-value logic for all registered outputs.
  always_comb begin
    state_nxt     = state;
    fifo_pop      = 1'b0;
    mem_adr_nxt   = mem_adr;
    mem_data_nxt  = mem_data;
    mem_wen_nxt   = 1'b0;
    mem_read_nxt  = 1'b0;
    rsp_valid_nxt = rsp_valid;
    rsp_write_nxt = rsp_write;
    rsp_data_nxt  = rsp_data;
`ifdef MEM_WR_VERIFY_EN
    rsp_err_nxt   = rsp_err_q;
`endif
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          mem_adr_nxt  = head_adr;
          mem_data_nxt = head_data;
          mem_wen_nxt  = head_write;
          mem_read_nxt = !head_write;
          state_nxt    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // mem_wen is still high during ACCESS, so it tells a write from a read.
        if (mem_wen) begin
`ifdef MEM_WR_VERIFY_EN
          mem_read_nxt  = 1'b1;
          state_nxt     = ST_VERIFY;
`else
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b1;
          rsp_data_nxt  = mem_data;
          state_nxt     = ST_RESP;
`endif
        end else begin
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b0;
          rsp_data_nxt  = mem_rdata;
`ifdef MEM_WR_VERIFY_EN
          rsp_err_nxt   = 1'b0;
`endif
          state_nxt     = ST_RESP;
        end
      end
`ifdef MEM_WR_VERIFY_EN
      ST_VERIFY: begin
        rsp_valid_nxt = 1'b1;
        rsp_write_nxt = 1'b1;
        rsp_data_nxt  = mem_rdata;
        rsp_err_nxt   = (mem_rdata != mem_data);
        state_nxt     = ST_RESP;
      end
`endif
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, bus and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_adr   <= '0;
      mem_data  <= '0;
      mem_wen   <= 1'b0;
      mem_read  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      mem_adr   <= mem_adr_nxt;
      mem_data  <= mem_data_nxt;
      mem_wen   <= mem_wen_nxt;
      mem_read  <= mem_read_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_write <= rsp_write_nxt;
      rsp_data  <= rsp_data_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a registered-write / combinational-read
// memory model. Expected responses are queued at request acceptance and
// checked in order when the DUT hands a response over.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [4:0] req_adr;
  logic [7:0] req_data;
  logic       rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [7:0] rsp_data;
  logic [4:0] mem_adr;
  logic [7:0] mem_data, mem_rdata;
  logic       mem_wen, mem_read;

  logic       preload;
  logic       corrupt;
  logic [7:0] mem    [32];
  logic [7:0] shadow [32];

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       e;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;
  int rd_cycles = 0;
  int prev_rd = 0;
  bit have_prev = 0;
  bit gap_on = 0;
  logic rsp_valid_d = 1'b0;

  mem_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_adr   (req_adr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_adr   (mem_adr),
    .mem_data  (mem_data),
    .mem_wen   (mem_wen),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    if (i == 29)      return 8'h08;
    else if (i == 30) return 8'h10;
    else              return 8'(i) ^ 8'h3C;
  endfunction

  // Memory model: registered write, combinational read gated by memRead.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (mem_wen) begin
      mem[mem_adr] <= mem_data;
    end
  end
  assign mem_rdata = mem_read ? (mem[mem_adr] ^ {7'b0, corrupt}) : 8'hxx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor and bus-timing observer.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && !rsp_valid_d) rsp_cyc = cyc;
      if (mem_read) begin
        rd_cycles++;
        if (gap_on && have_prev) chk("rd_gap", 32'(cyc - prev_rd), 32'd3);
        prev_rd   = cyc;
        have_prev = 1;
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_write", 32'(rsp_write), 32'(e.w));
          chk("rsp_data",  32'(rsp_data),  32'(e.d));
          chk("rsp_err",   32'(rsp_err),   32'(e.e));
        end
      end
    end
    rsp_valid_d = rsp_valid;
  end

  // Drive one request starting #1 after a rising edge; returns #1 after
  // the accepting edge. flip marks a write whose read-back is corrupted.
  task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d,
                      input logic flip = 1'b0);
    int   t = 0;
    exp_t e;
    req_valid = 1'b1;
    req_write = w;
    req_adr   = a;
    req_data  = d;
    while (!req_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("req_accept_bound", 32'(t < 200), 32'd1);
    @(posedge clk);
    e.w = w;
    e.e = 1'b0;
    if (w) begin
      shadow[a] = d;
`ifdef MEM_WR_VERIFY_EN
      e.d = d ^ {7'b0, flip};
      e.e = flip;
`else
      e.d = d;
`endif
    end else begin
      e.d = shadow[a];
    end
    sbq.push_back(e);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sbq.size() != 0 || rsp_valid) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_bound", 32'(t < 500), 32'd1);
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=%0t expected=<200000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] hold_data;
    logic       hold_write;
    int         vcnt;

    rst = 1'b1; preload = 1'b1; corrupt = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_adr = '0; req_data = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;

    // Reset values
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_wen",   32'(mem_wen),   32'd0);
    chk("rst_mem_read",  32'(mem_read),  32'd0);
    chk("rst_mem_adr",   32'(mem_adr),   32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single read, latency and read-strobe width
    rd_cycles = 0;
    send(1'b0, 5'd29, 8'h00);
    wait_drain();
    chk("t1_latency",   32'(rsp_cyc - acc_cyc), 32'd2);
    chk("t1_rd_cycles", 32'(rd_cycles), 32'd1);

    // 2: write then read back, in order
    send(1'b1, 5'd31, 8'hBB);
    send(1'b0, 5'd31, 8'h00);
    wait_drain();

    // 3: back-pressure: 2 queued + 1 in flight, response held stable
    rsp_ready = 1'b0;
    send(1'b1, 5'd3, 8'h33);
    send(1'b0, 5'd3, 8'h00);
    send(1'b0, 5'd30, 8'h00);
    chk("t3_req_ready_low", 32'(req_ready), 32'd0);
    chk("t3_rsp_valid",     32'(rsp_valid), 32'd1);
    hold_data  = rsp_data;
    hold_write = rsp_write;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_hold_data",  32'(rsp_data),  32'(hold_data));
    chk("t3_hold_write", 32'(rsp_write), 32'(hold_write));
    chk("t3_still_full", 32'(req_ready), 32'd0);
    chk("t3_queued",     32'(sbq.size()), 32'd3);
    rsp_ready = 1'b1;
    wait_drain();

    // 4: reset during the write access cycle
    send(1'b1, 5'd30, 8'h55);
    @(posedge clk); #1;
    chk("t4_in_access_wen", 32'(mem_wen), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    chk("t4_req_ready", 32'(req_ready), 32'd1);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t4_rsp_write", 32'(rsp_write), 32'd0);
    chk("t4_rsp_err",   32'(rsp_err),   32'd0);
    chk("t4_mem_wen",   32'(mem_wen),   32'd0);
    chk("t4_mem_adr",   32'(mem_adr),   32'd0);
    chk("t4_mem_data",  32'(mem_data),  32'd0);
    vcnt = 0;
    rd_cycles = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) vcnt++;
    end
    chk("t4_no_rsp",     32'(vcnt), 32'd0);
    chk("t4_no_access",  32'(rd_cycles), 32'd0);
    send(1'b0, 5'd30, 8'h00);
    wait_drain();

    // 5: streaming reads over the whole address range
    have_prev = 0;
    gap_on    = 1;
    for (int a = 0; a < 32; a++) send(1'b0, 5'(a), 8'h00);
    send(1'b0, 5'd0, 8'h00);
    wait_drain();
    gap_on = 0;

`ifdef MEM_WR_VERIFY_EN
    // 6: write verify with a corrupted read-back, then a clean write
    corrupt = 1'b1;
    send(1'b1, 5'd5, 8'hA5, 1'b1);
    wait_drain();
    corrupt = 1'b0;
    send(1'b1, 5'd5, 8'hA5);
    wait_drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
